// File: rtl/rs_pkg.sv
// Shared types and helpers for the reservation-station issue path.
package rs_pkg;

    localparam int unsigned ROB_IDX_W   = 4;
    localparam int unsigned ORD_W       = ROB_IDX_W + 1;
    localparam int unsigned ISSUE_W_MAX = 4;

    // ROB tag: {wrap bit, ROB index}
    typedef logic [ORD_W-1:0] ord_t;

    // Distance from the ROB head; modular subtraction keeps ordering correct across wrap
    function automatic ord_t rel_age(input ord_t tag, input ord_t head);
        return ord_t'(tag - head);
    endfunction

endpackage

// File: rtl/rs_age_pick.sv
// Combinational oldest-first picker: a binary tournament over {req, age}.
// Ties go to the lower entry index because the left child always holds lower indices.
module rs_age_pick
    import rs_pkg::*;
#(
    parameter int unsigned NUM_ENT = 16
) (
    input  logic [NUM_ENT-1:0] req,
    input  ord_t [NUM_ENT-1:0] order,
    input  ord_t               rob_head,
    output logic [NUM_ENT-1:0] gnt,
    output logic               any,
    output ord_t               win_order
);

    localparam int unsigned IDX_W = $clog2(NUM_ENT);
    localparam int unsigned LVLS  = $clog2(NUM_ENT);
    localparam int unsigned TOP   = LVLS - 1;

    // Tree levels: level 0 are the leaves, level TOP has the two finalists
    for (genvar lv = 0; lv < LVLS; lv++) begin : g_lvl
        localparam int unsigned N = NUM_ENT >> lv;
        logic [N-1:0]            v;
        ord_t [N-1:0]            age;
        logic [N-1:0][IDX_W-1:0] idx;

        if (lv == 0) begin : g_leaf
            for (genvar e = 0; e < N; e++) begin : g_e
                assign v[e]   = req[e];
                assign age[e] = rel_age(order[e], rob_head);
                assign idx[e] = IDX_W'(e);
            end
        end else begin : g_node
            for (genvar n = 0; n < N; n++) begin : g_n
                logic take_lo;
                assign take_lo = g_lvl[lv-1].v[2*n] &
                                 (~g_lvl[lv-1].v[2*n+1] |
                                  (g_lvl[lv-1].age[2*n] <= g_lvl[lv-1].age[2*n+1]));
                assign v[n]   = g_lvl[lv-1].v[2*n] | g_lvl[lv-1].v[2*n+1];
                assign age[n] = take_lo ? g_lvl[lv-1].age[2*n] : g_lvl[lv-1].age[2*n+1];
                assign idx[n] = take_lo ? g_lvl[lv-1].idx[2*n] : g_lvl[lv-1].idx[2*n+1];
            end
        end
    end

    logic             root_lo;
    logic [IDX_W-1:0] win_idx;

    // Final match between the two finalists
    assign root_lo   = g_lvl[TOP].v[0] &
                       (~g_lvl[TOP].v[1] | (g_lvl[TOP].age[0] <= g_lvl[TOP].age[1]));
    assign any       = g_lvl[TOP].v[0] | g_lvl[TOP].v[1];
    assign win_idx   = root_lo ? g_lvl[TOP].idx[0] : g_lvl[TOP].idx[1];
    assign gnt       = any ? (NUM_ENT'(1) << win_idx) : '0;
    assign win_order = any ? order[win_idx] : '0;

endmodule

// File: rtl/rs_multi_issue_select.sv
// Age-ordered multi-port issue selector: picks up to ISSUE_W oldest ready entries
// per cycle into per-port slots with a valid/ready handshake toward the FUs.
module rs_multi_issue_select
    import rs_pkg::*;
#(
    parameter int unsigned NUM_ENT = 16,
    parameter int unsigned ISSUE_W = 2
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            flush,
    input  logic [NUM_ENT-1:0]              req,
    input  ord_t [NUM_ENT-1:0]              order,
    input  ord_t                            rob_head,
    input  logic [ISSUE_W-1:0]              fu_ready,
    output logic [ISSUE_W-1:0]              iss_valid,
    output logic [ISSUE_W-1:0][NUM_ENT-1:0] iss_gnt,
    output ord_t [ISSUE_W-1:0]              iss_order,
    output logic [NUM_ENT-1:0]              iss_fire
);

    logic [ISSUE_W-1:0]              stall;
    logic [ISSUE_W-1:0]              fire;
    logic [NUM_ENT-1:0]              held;
    logic [NUM_ENT-1:0]              elig;
    logic [ISSUE_W-1:0][NUM_ENT-1:0] pick_gnt;
    logic [ISSUE_W-1:0]              pick_any;
    ord_t [ISSUE_W-1:0]              pick_ord;
    logic [ISSUE_W-1:0]              nxt_valid;
    logic [ISSUE_W-1:0][NUM_ENT-1:0] nxt_gnt;
    ord_t [ISSUE_W-1:0]              nxt_order;

    assign stall = iss_valid & ~fu_ready;
    assign fire  = iss_valid & fu_ready;

    // Entries parked in stalled slots are held back; fired entries are reported to the RS
    always_comb begin
        held     = '0;
        iss_fire = '0;
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            if (stall[k]) held     = held | iss_gnt[k];
            if (fire[k])  iss_fire = iss_fire | iss_gnt[k];
        end
    end

    assign elig = req & ~held;

    // Picker chain: stage i sees the eligible set minus the winners of earlier stages
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_stage
        logic [NUM_ENT-1:0] cand;
        logic [NUM_ENT-1:0] gnt;
        logic               any;
        ord_t               ord;

        if (i == 0) begin : g_first
            assign cand = elig;
        end else begin : g_rest
            assign cand = g_stage[i-1].cand & ~g_stage[i-1].gnt;
        end

        rs_age_pick #(
            .NUM_ENT (NUM_ENT)
        ) u_pick (
            .req       (cand),
            .order     (order),
            .rob_head  (rob_head),
            .gnt       (gnt),
            .any       (any),
            .win_order (ord)
        );

        assign pick_gnt[i] = gnt;
        assign pick_any[i] = any;
        assign pick_ord[i] = ord;
    end

    // The i-th free slot (ascending k) takes the i-th oldest pick
    always_comb begin
        int rank;
        rank      = 0;
        nxt_valid = '0;
        nxt_gnt   = '0;
        nxt_order = '0;
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            if (!stall[k]) begin
                for (int j = 0; j < int'(ISSUE_W); j++) begin
                    if (rank == j) begin
                        nxt_valid[k] = pick_any[j];
                        nxt_gnt[k]   = pick_gnt[j];
                        nxt_order[k] = pick_ord[j];
                    end
                end
                rank = rank + 1;
            end
        end
    end

    // Slot registers: flush squashes everything, stalled slots hold, free slots reload
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iss_valid <= '0;
            iss_gnt   <= '0;
            iss_order <= '0;
        end else if (flush) begin
            iss_valid <= '0;
            iss_gnt   <= '0;
            iss_order <= '0;
        end else begin
            for (int k = 0; k < int'(ISSUE_W); k++) begin
                if (!stall[k]) begin
                    iss_valid[k] <= nxt_valid[k];
                    iss_gnt[k]   <= nxt_gnt[k];
                    iss_order[k] <= nxt_order[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_multi_issue_select.sv
// Bench for rs_multi_issue_select: directed scenarios plus randomized traffic,
// checked every cycle against a slot-level reference model.
module tb_rs_multi_issue_select;
    import rs_pkg::*;

    localparam int NE  = 8;
    localparam int ISW = 2;
    localparam int AGE_MOD = 1 << ORD_W;

    logic                    clock    = 1'b0;
    logic                    reset_n  = 1'b0;
    logic                    flush    = 1'b0;
    logic [NE-1:0]           req      = '0;
    ord_t [NE-1:0]           order    = '0;
    ord_t                    rob_head = '0;
    logic [ISW-1:0]          fu_ready = '0;
    logic [ISW-1:0]          iss_valid;
    logic [ISW-1:0][NE-1:0]  iss_gnt;
    ord_t [ISW-1:0]          iss_order;
    logic [NE-1:0]           iss_fire;

    always #5 clock = ~clock;

    rs_multi_issue_select #(
        .NUM_ENT (NE),
        .ISSUE_W (ISW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .req       (req),
        .order     (order),
        .rob_head  (rob_head),
        .fu_ready  (fu_ready),
        .iss_valid (iss_valid),
        .iss_gnt   (iss_gnt),
        .iss_order (iss_order),
        .iss_fire  (iss_fire)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one record per issue slot ----------------
    bit m_v[ISW];
    int m_e[ISW];
    int m_o[ISW];
    bit taken[NE];
    int picks[ISW];
    int npick;

    function automatic int age_of(input int tag, input int head);
        return (tag - head + AGE_MOD) % AGE_MOD;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n || flush) begin
            for (int k = 0; k < ISW; k++) begin
                m_v[k] = 0; m_e[k] = 0; m_o[k] = 0;
            end
        end else begin
            for (int e = 0; e < NE; e++) taken[e] = !req[e];
            for (int k = 0; k < ISW; k++)
                if (m_v[k] && !fu_ready[k]) taken[m_e[k]] = 1;
            npick = 0;
            for (int p = 0; p < ISW; p++) begin
                int best, bkey, key;
                best = -1; bkey = 0;
                for (int e = 0; e < NE; e++) begin
                    if (!taken[e]) begin
                        key = age_of(int'(order[e]), int'(rob_head)) * NE + e;
                        if (best < 0 || key < bkey) begin best = e; bkey = key; end
                    end
                end
                if (best >= 0) begin
                    picks[npick] = best;
                    taken[best]  = 1;
                    npick++;
                end
            end
            begin
                int j;
                j = 0;
                for (int k = 0; k < ISW; k++) begin
                    if (!m_v[k] || fu_ready[k]) begin
                        if (j < npick) begin
                            m_v[k] = 1; m_e[k] = picks[j]; m_o[k] = int'(order[picks[j]]);
                        end else begin
                            m_v[k] = 0;
                        end
                        j++;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clock) begin
        if (cmp_en) begin
            logic [NE-1:0] m_fire;
            m_fire = '0;
            for (int k = 0; k < ISW; k++) begin
                chk($sformatf("valid[%0d]", k), 32'(iss_valid[k]), 32'(m_v[k]));
                if (m_v[k]) begin
                    chk($sformatf("gnt[%0d]", k), 32'(iss_gnt[k]), 32'(1) << m_e[k]);
                    chk($sformatf("order[%0d]", k), 32'(iss_order[k]), 32'(m_o[k]));
                    if (fu_ready[k]) m_fire[m_e[k]] = 1'b1;
                end
            end
            if (iss_valid == 2'b11)
                chk("gnt_exclusive", 32'(iss_gnt[0] & iss_gnt[1]), 32'd0);
            chk("fire", 32'(iss_fire), 32'(m_fire));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        cmp_en = 1;
        chk("reset_valid", 32'(iss_valid), 32'd0);

        // Reset mid-run
        req = 8'hFF; fu_ready = 2'b11;
        for (int e = 0; e < NE; e++) order[e] = ORD_W'(e);
        tick();
        chk("prereset_valid", 32'(iss_valid), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(iss_valid), 32'd0);
        chk("async_fire", 32'(iss_fire), 32'd0);
        chk("async_gnt", 32'(iss_gnt), 32'd0);
        req = '0;
        #3 reset_n = 1'b1;
        tick(); tick();
        chk("post_reset_valid", 32'(iss_valid), 32'd0);

        // Dual pick
        rob_head = 5'd0; req = 8'b0010_1100;
        order[2] = 5'd7; order[3] = 5'd3; order[5] = 5'd1; fu_ready = 2'b11;
        tick();
        chk("dual_valid", 32'(iss_valid), 32'd3);
        chk("dual_gnt0", 32'(iss_gnt[0]), 32'h20);
        chk("dual_ord0", 32'(iss_order[0]), 32'd1);
        chk("dual_gnt1", 32'(iss_gnt[1]), 32'h08);
        chk("dual_ord1", 32'(iss_order[1]), 32'd3);

        // Wrap-around and equal-tag tie
        rob_head = 5'd30; req = 8'b0000_0011;
        order[0] = 5'b0_0001; order[1] = 5'b1_1111;
        tick();
        chk("wrap_gnt0", 32'(iss_gnt[0]), 32'h02);
        chk("wrap_ord0", 32'(iss_order[0]), 32'd31);
        chk("wrap_gnt1", 32'(iss_gnt[1]), 32'h01);
        req = 8'b0101_0000; order[4] = 5'd9; order[6] = 5'd9;
        tick();
        chk("tie_gnt0", 32'(iss_gnt[0]), 32'h10);
        chk("tie_gnt1", 32'(iss_gnt[1]), 32'h40);

        // Stall hold; entry2 tag equals rob_head (age 0)
        rob_head = 5'd6; order[2] = 5'd6; order[3] = 5'd10;
        req = 8'b0000_1100; fu_ready = 2'b11;
        tick();
        chk("stall_setup_gnt0", 32'(iss_gnt[0]), 32'h04);
        chk("stall_setup_ord0", 32'(iss_order[0]), 32'd6);
        chk("stall_setup_gnt1", 32'(iss_gnt[1]), 32'h08);
        fu_ready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_valid", 32'(iss_valid), 32'd3);
            chk("stall_gnt0", 32'(iss_gnt[0]), 32'h04);
            chk("stall_gnt1", 32'(iss_gnt[1]), 32'h08);
            chk("stall_fire", 32'(iss_fire), 32'h08);
        end
        fu_ready = 2'b11; req = '0;
        #1;
        chk("release_fire", 32'(iss_fire), 32'h0C);
        tick();
        chk("release_valid", 32'(iss_valid), 32'd0);
        chk("release_fire_once", 32'(iss_fire), 32'd0);

        // Flush beats stall and a pending pick
        rob_head = 5'd0; order[0] = 5'd2; order[1] = 5'd1;
        req = 8'b0000_0011; fu_ready = 2'b11;
        tick();
        chk("flush_setup_valid", 32'(iss_valid), 32'd3);
        chk("flush_setup_gnt0", 32'(iss_gnt[0]), 32'h02);
        fu_ready = 2'b00; req = 8'hF0; flush = 1'b1;
        tick();
        chk("flush_valid", 32'(iss_valid), 32'd0);
        chk("flush_fire", 32'(iss_fire), 32'd0);
        flush = 1'b0; req = '0; fu_ready = 2'b11;
        tick();

        // Randomized traffic
        for (int c = 0; c < 10000; c++) begin
            req      = NE'($urandom);
            for (int e = 0; e < NE; e++) order[e] = ORD_W'($urandom_range(0, AGE_MOD - 1));
            rob_head = ORD_W'($urandom_range(0, AGE_MOD - 1));
            fu_ready = ISW'($urandom);
            flush    = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
